// File: rtl/mem_req_arbiter.sv
// Arbitrates NUM_REQ lane requests onto the shared register memory, one transaction at a time.
// Optional build macro MEM_ARB_FIXED_PRIO_EN selects fixed priority (lowest lane wins) instead of round-robin.
module mem_req_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int AW        = 8,
    parameter int DW        = 32,
    parameter int MEM_DEPTH = 8,
    parameter int READ_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [AW-1:0]         mem_read_adr,
    output logic [AW-1:0]         mem_write_adr,
    output logic [DW-1:0]         mem_in_data,
    input  logic [DW-1:0]         mem_out_data,
    output logic [1:0]            dbg_state
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   win_id;
    logic             win_found;
    int               arb_idx;
    logic             lat_we;
    logic [IDW-1:0]   lat_id;
    logic [CW-1:0]    wait_cnt;
    logic             wait_last;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;
    logic             sel_err;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]   rr_ptr;
`endif

    // Winner search: first valid lane starting at the search origin, wrapping at NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        arb_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            arb_idx = k;
`else
            arb_idx = int'(rr_ptr) + k;
            if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
`endif
            if (!win_found && req_valid[IDW'(arb_idx)]) begin
                win_found = 1'b1;
                win_id    = IDW'(arb_idx);
            end
        end
    end

    assign sel_we    = req_we[win_id];
    assign sel_addr  = req_addr[int'(win_id)*AW +: AW];
    assign sel_wdata = req_wdata[int'(win_id)*DW +: DW];
    assign sel_err   = ({1'b0, sel_addr} >= DEPTH_L);
    assign wait_last = (wait_cnt == CW'(READ_LAT - 1));
    assign dbg_state = state;

    // Handshakes: a transfer occurs on a rising edge where valid and ready are both 1.
    // req_ready is only offered in IDLE; rsp_valid is held with stable payload until rsp_ready.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state == IDLE && win_found) req_ready[win_id] = 1'b1;
        if (state == RESP)              rsp_valid[lat_id] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (win_found) state_nxt = sel_err ? RESP : ISSUE;
            ISSUE: state_nxt = lat_we ? RESP : WAIT;
            WAIT:  if (wait_last) state_nxt = RESP;
            RESP:  if (rsp_ready[lat_id]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we        <= 1'b0;
            lat_id        <= '0;
            wait_cnt      <= '0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_read_adr  <= '0;
            mem_write_adr <= '0;
            mem_in_data   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr        <= '0;
`endif
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        lat_we    <= sel_we;
                        lat_id    <= win_id;
                        wait_cnt  <= '0;
                        rsp_rdata <= '0;
                        rsp_err   <= sel_err;
                        // Strobes are registered so they are high for exactly the ISSUE cycle.
                        if (!sel_err) begin
                            if (sel_we) begin
                                mem_write     <= 1'b1;
                                mem_write_adr <= sel_addr;
                                mem_in_data   <= sel_wdata;
                            end else begin
                                mem_read      <= 1'b1;
                                mem_read_adr  <= sel_addr;
                            end
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (wait_last) rsp_rdata <= mem_out_data;
                end
                RESP: begin
`ifndef MEM_ARB_FIXED_PRIO_EN
                    if (rsp_ready[lat_id])
                        rr_ptr <= (lat_id == IDW'(NUM_REQ - 1)) ? '0 : lat_id + IDW'(1);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
